// File: rtl/fetch_stage_queue_if.sv
// Handshake bundle between fetch stage 0 (producer) and fetch stage 1 (consumer).
// The queue takes the slave view; the IF0/IF1 side takes the master view.
interface fetch_stage_queue_if #(
  parameter int PC_W  = 32,
  parameter int TAG_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [PC_W-1:0]  in_pc;
  logic [PC_W-1:0]  in_pc_next;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  out_pc;
  logic [PC_W-1:0]  out_pc_next;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_pc, in_pc_next, in_tag, out_ready,
    input  in_ready, out_valid, out_pc, out_pc_next, out_tag
  );

  modport slave (
    input  in_valid, in_pc, in_pc_next, in_tag, out_ready,
    output in_ready, out_valid, out_pc, out_pc_next, out_tag
  );
endinterface

// File: rtl/fetch_stage_queue.sv
// DEPTH-entry decoupling queue between IF0 and IF1 with whole-queue flush,
// occupancy output and a saturating count of entries discarded by flush.
module fetch_stage_queue_chk #(
  parameter int PC_W  = 32,
  parameter int TAG_W = 2,
  parameter int DEPTH = 4
) (
  input logic                     clk,
  input logic                     rst,
  input logic                     flush,
  input logic                     out_valid,
  input logic                     out_ready,
  input logic [PC_W-1:0]          out_pc,
  input logic [PC_W-1:0]          out_pc_next,
  input logic [TAG_W-1:0]         out_tag,
  input logic [$clog2(DEPTH):0]   count
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic             hold_r;
  logic [PC_W-1:0]  snap_pc_r;
  logic [PC_W-1:0]  snap_pc_next_r;
  logic [TAG_W-1:0] snap_tag_r;

  // A stalled head must present identical fields on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r         <= 1'b0;
      snap_pc_r      <= '0;
      snap_pc_next_r <= '0;
      snap_tag_r     <= '0;
    end else begin
      if (hold_r) begin
        a_head_stable: assert (out_valid && out_pc == snap_pc_r &&
                               out_pc_next == snap_pc_next_r && out_tag == snap_tag_r);
      end
      a_count_bound: assert (count <= OCC_W'(DEPTH));
      hold_r         <= out_valid & ~out_ready & ~flush;
      snap_pc_r      <= out_pc;
      snap_pc_next_r <= out_pc_next;
      snap_tag_r     <= out_tag;
    end
  end
endmodule

module fetch_stage_queue #(
  parameter int PC_W  = 32,
  parameter int TAG_W = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  fetch_stage_queue_if.slave     bus,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       flush_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] FULL_C = OCC_W'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_next;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [OCC_W-1:0] count_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic             in_ready_s;
  logic             out_valid_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic [OCC_W-1:0] count_nxt_s;
  logic [SUM_W-1:0] flush_sum_s;
  logic [CNT_W-1:0] flush_cnt_nxt_s;
  entry_t           in_entry_s;
  entry_t           head_s;

  // Handshake qualifiers; full/empty come from the occupancy register only.
  always_comb begin
    in_ready_s  = (count_r != FULL_C);
    out_valid_s = (count_r != OCC_W'(0));
    accept_s    = bus.in_valid & in_ready_s;
    push_s      = accept_s & ~flush;
    pop_s       = out_valid_s & bus.out_ready & ~flush;
    in_entry_s  = '{pc: bus.in_pc, pc_next: bus.in_pc_next, tag: bus.in_tag};
  end

  // Occupancy update for the non-flush case.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + OCC_W'(1);
      2'b01:   count_nxt_s = count_r - OCC_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Flush discards the stored entries plus an entry offered-and-acceptable this cycle.
  always_comb begin
    flush_sum_s     = {1'b0, flush_cnt_r} + SUM_W'(count_r) + SUM_W'(accept_s);
    flush_cnt_nxt_s = flush_cnt_r;
    if (!flush) begin
      flush_cnt_nxt_s = flush_cnt_r;
    end else if (flush_sum_s[CNT_W]) begin
      flush_cnt_nxt_s = {CNT_W{1'b1}};
    end else begin
      flush_cnt_nxt_s = flush_sum_s[CNT_W-1:0];
    end
  end

  // Entry storage; flush zeroes every slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= in_entry_s;
    end
  end

  // Pointers, occupancy and discard counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r    <= PTR_W'(0);
      wr_ptr_r    <= PTR_W'(0);
      count_r     <= OCC_W'(0);
      flush_cnt_r <= CNT_W'(0);
    end else begin
      flush_cnt_r <= flush_cnt_nxt_s;
      if (flush) begin
        rd_ptr_r <= PTR_W'(0);
        wr_ptr_r <= PTR_W'(0);
        count_r  <= OCC_W'(0);
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end
        count_r <= count_nxt_s;
      end
    end
  end

  // Head fields are masked to zero while the queue is empty.
  always_comb begin
    head_s = mem_r[rd_ptr_r];
    if (out_valid_s) begin
      bus.out_pc      = head_s.pc;
      bus.out_pc_next = head_s.pc_next;
      bus.out_tag     = head_s.tag;
    end else begin
      bus.out_pc      = '0;
      bus.out_pc_next = '0;
      bus.out_tag     = '0;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign count         = count_r;
  assign flush_cnt     = flush_cnt_r;

  fetch_stage_queue_chk #(
    .PC_W  (PC_W),
    .TAG_W (TAG_W),
    .DEPTH (DEPTH)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .out_valid   (out_valid_s),
    .out_ready   (bus.out_ready),
    .out_pc      (bus.out_pc),
    .out_pc_next (bus.out_pc_next),
    .out_tag     (bus.out_tag),
    .count       (count_r)
  );
endmodule

// File: tb/tb_fetch_stage_queue.sv
// Randomised scoreboard bench for fetch_stage_queue: a queue-of-entries model
// predicts accepts, flush discards and head order; a negedge monitor compares.
module tb_fetch_stage_queue;
  localparam int PC_W  = 32;
  localparam int TAG_W = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = 5;
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int unsigned FCNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pcn;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [OCC_W-1:0] count;
  logic [CNT_W-1:0] flush_cnt;

  fetch_stage_queue_if #(.PC_W(PC_W), .TAG_W(TAG_W)) bus ();

  fetch_stage_queue #(
    .PC_W  (PC_W),
    .TAG_W (TAG_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .count     (count),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  ent_t        exp_q[$];
  int unsigned fcnt_m  = 0;
  int          checks  = 0;
  int          errors  = 0;
  bit          started = 1'b0;
  bit          p_acc   = 1'b0;
  bit          p_push  = 1'b0;
  bit          p_flush = 1'b0;
  ent_t        p_ent;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Retire the effect of the previous cycle's inputs into the model.
  task automatic apply_pending();
    if (p_flush) begin
      fcnt_m = fcnt_m + exp_q.size() + (p_acc ? 1 : 0);
      if (fcnt_m > FCNT_MAX) fcnt_m = FCNT_MAX;
      exp_q.delete();
    end else if (p_push) begin
      exp_q.push_back(p_ent);
    end
    p_acc   = 1'b0;
    p_push  = 1'b0;
    p_flush = 1'b0;
  endtask

  task automatic step(input bit v, input logic [PC_W-1:0] pc, input logic [PC_W-1:0] pcn,
                      input logic [TAG_W-1:0] tag, input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    apply_pending();
    bus.in_valid   = v;
    bus.in_pc      = pc;
    bus.in_pc_next = pcn;
    bus.in_tag     = tag;
    bus.out_ready  = ordy;
    flush          = fl;
    p_acc   = v && (exp_q.size() != DEPTH);
    p_flush = fl;
    p_push  = p_acc && !fl;
    p_ent   = '{pc: pc, pcn: pcn, tag: tag};
  endtask

  // Monitor: status every cycle, head compared and popped on each consumption.
  always @(negedge clk) begin
    if (!rst && started) begin
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("in_ready", 64'(bus.in_ready), 64'(exp_q.size() != DEPTH));
      chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      chk("flush_cnt", 64'(flush_cnt), 64'(fcnt_m));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL head: got valid pc %0h expected empty queue", bus.out_pc);
        end else begin
          chk("out_pc", 64'(bus.out_pc), 64'(exp_q[0].pc));
          chk("out_pc_next", 64'(bus.out_pc_next), 64'(exp_q[0].pcn));
          chk("out_tag", 64'(bus.out_tag), 64'(exp_q[0].tag));
          if (bus.out_ready && !flush) void'(exp_q.pop_front());
        end
      end else begin
        chk("empty_out", {bus.out_pc, bus.out_pc_next[PC_W-3:0], bus.out_tag}, 64'd0);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_pc      = '0;
    bus.in_pc_next = '0;
    bus.in_tag     = '0;
    bus.out_ready  = 1'b0;
    #22;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
    chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
    started = 1'b1;

    // Fill to full with the consumer stalled.
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h1c00_0000 + 32'(4 * i), 32'h1c00_0004 + 32'(4 * i), 2'(i), 1'b0, 1'b0);
    step(1'b1, 32'h0bad_0000, 32'h0bad_0004, 2'd3, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_head", 64'(bus.out_pc), 64'h1c00_0000);

    // Drain.
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    chk("drained_count", 64'(count), 64'd0);

    // Streaming through wrapping pointers.
    for (int i = 0; i < 20; i++)
      step(1'b1, 32'h2000_0000 + 32'(4 * i), 32'h3000_0000 + 32'(i), 2'(i + 1), 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);

    // Three queued, then flush with a same-cycle offer.
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h4000_0000 + 32'(4 * i), 32'h4000_0100, 2'd1, 1'b0, 1'b0);
    step(1'b1, 32'hdead_beec, 32'hdead_bef0, 2'd2, 1'b1, 1'b1);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_cnt4", 64'(flush_cnt), 64'd4);

    // Flush while empty with nothing offered.
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    chk("eflush_cnt", 64'(flush_cnt), 64'd4);
    chk("eflush_ready", 64'(bus.in_ready), 64'd1);

    // Asynchronous reset between edges with two entries held.
    step(1'b1, 32'h5000_0000, 32'h5000_0004, 2'd1, 1'b0, 1'b0);
    step(1'b1, 32'h5000_0004, 32'h5000_0008, 2'd0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    chk("pre_rst_count", 64'(count), 64'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_flush_cnt", 64'(flush_cnt), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    fcnt_m  = 0;
    p_acc   = 1'b0;
    p_push  = 1'b0;
    p_flush = 1'b0;

    // Random traffic, enough flushes to reach counter saturation.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, PC_W'($urandom), PC_W'($urandom), TAG_W'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);
    chk("final_empty", 64'(count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage_queue.md
Name: fetch_stage_queue

Overview:
- Parametrised decoupling queue between fetch stage 0 (PC generation / TLB lookup) and fetch stage 1 (I-cache response).
- Next-generation replacement for the single-entry IF0->IF1 stage register.
- Holds up to DEPTH in-flight fetch entries {pc, pc_next, tag} with valid/ready handshakes on both sides.
- Supports whole-queue flush, occupancy reporting and a flush-discard performance counter.

Parameters:
PC_W, 32, width of the pc and pc_next fields
TAG_W, 2, width of the sideband tag carried per entry (bit0 = tlb_rvalid; other bits free for cause/miss flags)
DEPTH, 4, number of entries; power of two, >= 2
CNT_W, 16, width of the flush-discard counter

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous active-high reset
flush  in  1  discard all entries and any same-cycle push
in_valid  in  1  IF0 presents an entry
in_ready  out  1  queue can accept an entry
in_pc  in  PC_W  fetch pc
in_pc_next  in  PC_W  predicted next pc
in_tag  in  TAG_W  sideband (tlb_rvalid etc.)
out_valid  out  1  head entry valid
out_ready  in  1  IF1 consumes head
out_pc  out  PC_W  head pc
out_pc_next  out  PC_W  head pc_next
out_tag  out  TAG_W  head tag
count  out  $clog2(DEPTH)+1  current occupancy
flush_cnt  out  CNT_W  total entries discarded by flush, saturating

Behaviour:
- Reset (asynchronous on rst high): rd_ptr = wr_ptr = 0, count = 0, flush_cnt = 0, all storage = 0. Resulting outputs: out_valid = 0, in_ready = 1, out_* = 0.
- Storage: DEPTH-entry register array; rd_ptr and wr_ptr are $clog2(DEPTH)-bit and wrap modulo DEPTH. Full/empty are derived from count, never from pointer equality.
- in_ready = (count != DEPTH). It is a function of registered state only; there is no combinational path from out_ready to in_ready.
- out_valid = (count != 0).
- out_pc, out_pc_next and out_tag are read from storage[rd_ptr] when out_valid = 1 and forced to 0 when empty.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1 at the earliest. There is no same-cycle bypass.
- Push and pop in the same cycle: both pointers advance and count is unchanged. When full, in_ready = 0, so this case cannot occur with a push. When the queue holds one entry, simultaneous push and pop is legal; the new entry becomes the head next cycle.
- Flush has highest priority below rst.
  - Next cycle: rd_ptr = wr_ptr = 0 and count = 0.
  - Storage entries are zeroed.
  - Any same-cycle push is dropped; any same-cycle pop is not counted as a consumption.
- flush_cnt on flush: flush_cnt += count + (in_valid & in_ready). It saturates at 2^CNT_W-1.
- Flush while empty with no push: flush_cnt is unchanged.
- in_* values are sampled only on push. Values on a rejected or flushed cycle have no effect.
- Each field of an entry is carried unmodified.
- Reset asserted mid-operation: all state clears immediately, independent of clk. The first push may be accepted on the first clk edge after rst deasserts.
- Verification assertions:
  - count never exceeds DEPTH.
  - out_* are stable while out_valid & ~out_ready & ~flush.
  - No entry is duplicated or reordered; output order equals push order.

Test Plan:
- Reset then 4 single pushes (pc=0x1c000000, +4, +8, +C; out_ready=0) -> in_ready goes 0 after the 4th; count=4; out_pc=0x1c000000 stable.
- From full, out_ready=1 for 4 cycles with in_valid=0 -> out_pc sequence 0x1c000000,0x1c000004,0x1c000008,0x1c00000C; then out_valid=0, out_pc=0, count=0.
- Continuous streaming with in_valid=out_ready=1 for 20 cycles -> count stays 1 after the first cycle; outputs are in-order with 1-cycle latency; pointers wrap past DEPTH without loss.
- 3 entries queued, then flush together with in_valid=1 -> next cycle count=0, out_valid=0, flush_cnt=4; the pushed pc never appears at the outputs.
- Empty queue with flush=1, in_valid=0 -> flush_cnt unchanged; in_ready stays 1.
- Async rst pulse between clock edges while count=2 -> out_valid=0 and count=0 before the next edge; flush_cnt=0.
